// File: rtl/fpu_pkg.sv
// Shared definitions for the fp16 FPU dispatch slice: opcodes, FSM encoding
// and the default datapath width.
package fpu_pkg;

   localparam int DATA_W_DEF = 16;

   localparam logic [3:0] OP_FADD = 4'b1110;
   localparam logic [3:0] OP_FMUL = 4'b1111;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_WB    = 2'd3
   } state_t;

   function automatic logic is_fp_op(input logic [3:0] op);
      return (op == OP_FADD) || (op == OP_FMUL);
   endfunction

endpackage

// File: rtl/fpu_wb_slot.sv
// Single-entry ready/valid holding register for a writeback (rd, data) pair.
// Loads only while empty; empties on a completed transfer.
module fpu_wb_slot
   import fpu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int RD_W   = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [RD_W-1:0]   load_rd,
   input  logic [DATA_W-1:0] load_data,
   output logic              in_rdy,
   output logic              wb_vld,
   output logic [RD_W-1:0]   wb_rd,
   output logic [DATA_W-1:0] wb_data,
   input  logic              wb_rdy
);

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_vld  <= 1'b0;
         wb_rd   <= '0;
         wb_data <= '0;
      end else if (load && !wb_vld) begin
         wb_vld  <= 1'b1;
         wb_rd   <= load_rd;
         wb_data <= load_data;
      end else if (wb_vld && wb_rdy) begin
         wb_vld  <= 1'b0;
      end
   end

   assign in_rdy = ~wb_vld;

endmodule

// File: rtl/fpu_dispatch.sv
// Issue-side controller for the fp16 FPU: accepts one instruction, strobes the
// FPU, waits for a result or timeout, and hands the result to writeback.
module fpu_dispatch
   import fpu_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int RD_W    = 3,
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req_vld,
   output logic              o_req_rdy,
   input  logic [3:0]        i_opcode,
   input  logic [DATA_W-1:0] i_rs1_data,
   input  logic [DATA_W-1:0] i_rs2_data,
   input  logic [RD_W-1:0]   i_rd,
   output logic              o_fpu_vld,
   output logic [DATA_W-1:0] o_fpu_a,
   output logic [DATA_W-1:0] o_fpu_b,
   output logic [3:0]        o_fpu_opcode,
   input  logic [DATA_W-1:0] i_fpu_res,
   input  logic              i_fpu_res_vld,
   input  logic              i_fpu_overflow,
   output logic              o_wb_vld,
   output logic [RD_W-1:0]   o_wb_rd,
   output logic [DATA_W-1:0] o_wb_data,
   input  logic              i_wb_rdy,
   output logic              o_busy,
   output logic              o_illegal,
   output logic              o_timeout,
   output logic              o_ovf_sticky,
   input  logic              i_ovf_clr
);

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   state_t            state;
   state_t            state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_nxt;
   logic [RD_W-1:0]   rd_q;
   logic              accept;
   logic              capture;
   logic              illegal_nxt;
   logic              timeout_nxt;
   logic              slot_in_rdy;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // A result arriving together with the last timeout cycle is still taken.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      accept      = 1'b0;
      capture     = 1'b0;
      illegal_nxt = 1'b0;
      timeout_nxt = 1'b0;
      case (state)
         S_IDLE: begin
            if (i_req_vld && o_req_rdy) begin
               accept = 1'b1;
               if (is_fp_op(i_opcode)) begin
                  state_nxt = S_ISSUE;
               end else begin
                  illegal_nxt = 1'b1;
               end
            end
         end
         S_ISSUE: begin
            if (i_fpu_res_vld) begin
               capture   = 1'b1;
               state_nxt = S_WB;
            end else begin
               cnt_nxt   = CNT_W'(1);
               state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (i_fpu_res_vld) begin
               capture   = 1'b1;
               state_nxt = S_WB;
            end else if (cnt == TIMEOUT_C) begin
               timeout_nxt = 1'b1;
               cnt_nxt     = '0;
               state_nxt   = S_IDLE;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         S_WB: begin
            if (o_wb_vld && i_wb_rdy) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         o_fpu_a      <= '0;
         o_fpu_b      <= '0;
         o_fpu_opcode <= '0;
         rd_q         <= '0;
         cnt          <= '0;
         o_illegal    <= 1'b0;
         o_timeout    <= 1'b0;
         o_ovf_sticky <= 1'b0;
      end else begin
         if (accept) begin
            o_fpu_a      <= i_rs1_data;
            o_fpu_b      <= i_rs2_data;
            o_fpu_opcode <= i_opcode;
            rd_q         <= i_rd;
         end
         cnt       <= cnt_nxt;
         o_illegal <= illegal_nxt;
         o_timeout <= timeout_nxt;
         if (capture && i_fpu_overflow) begin
            o_ovf_sticky <= 1'b1;
         end else if (i_ovf_clr) begin
            o_ovf_sticky <= 1'b0;
         end
      end
   end

   fpu_wb_slot #(
      .DATA_W (DATA_W),
      .RD_W   (RD_W)
   ) u_wb_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (capture & slot_in_rdy),
      .load_rd   (rd_q),
      .load_data (i_fpu_res),
      .in_rdy    (slot_in_rdy),
      .wb_vld    (o_wb_vld),
      .wb_rd     (o_wb_rd),
      .wb_data   (o_wb_data),
      .wb_rdy    (i_wb_rdy)
   );

   assign o_fpu_vld = (state == S_ISSUE);
   assign o_busy    = (state != S_IDLE);
   assign o_req_rdy = (state == S_IDLE) & ~rst;

endmodule

// File: tb/tb_fpu_dispatch.sv
// Scoreboard bench for fpu_dispatch: directed ops push expected writebacks,
// a monitor pops and compares on every completed writeback transfer.
module tb_fpu_dispatch;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req_vld;
   logic        o_req_rdy;
   logic [3:0]  i_opcode;
   logic [15:0] i_rs1_data;
   logic [15:0] i_rs2_data;
   logic [2:0]  i_rd;
   logic        o_fpu_vld;
   logic [15:0] o_fpu_a;
   logic [15:0] o_fpu_b;
   logic [3:0]  o_fpu_opcode;
   logic [15:0] i_fpu_res;
   logic        i_fpu_res_vld;
   logic        i_fpu_overflow;
   logic        o_wb_vld;
   logic [2:0]  o_wb_rd;
   logic [15:0] o_wb_data;
   logic        i_wb_rdy;
   logic        o_busy;
   logic        o_illegal;
   logic        o_timeout;
   logic        o_ovf_sticky;
   logic        i_ovf_clr;

   typedef struct packed {
      logic [2:0]  rd;
      logic [15:0] data;
   } wb_exp_t;

   wb_exp_t exp_q[$];
   int      errors = 0;
   int      checks = 0;

   // FPU model controls
   bit          fpu_en;
   int          fpu_lat;
   logic [15:0] fpu_res_val;
   logic        fpu_ovf_val;
   logic        fpu_vld_d;
   logic        late_vld;
   int          pend;

   always #5 clk = ~clk;

   fpu_dispatch #(
      .DATA_W  (16),
      .RD_W    (3),
      .TIMEOUT (15),
      .CNT_W   (8)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .i_req_vld      (i_req_vld),
      .o_req_rdy      (o_req_rdy),
      .i_opcode       (i_opcode),
      .i_rs1_data     (i_rs1_data),
      .i_rs2_data     (i_rs2_data),
      .i_rd           (i_rd),
      .o_fpu_vld      (o_fpu_vld),
      .o_fpu_a        (o_fpu_a),
      .o_fpu_b        (o_fpu_b),
      .o_fpu_opcode   (o_fpu_opcode),
      .i_fpu_res      (i_fpu_res),
      .i_fpu_res_vld  (i_fpu_res_vld),
      .i_fpu_overflow (i_fpu_overflow),
      .o_wb_vld       (o_wb_vld),
      .o_wb_rd        (o_wb_rd),
      .o_wb_data      (o_wb_data),
      .i_wb_rdy       (i_wb_rdy),
      .o_busy         (o_busy),
      .o_illegal      (o_illegal),
      .o_timeout      (o_timeout),
      .o_ovf_sticky   (o_ovf_sticky),
      .i_ovf_clr      (i_ovf_clr)
   );

   assign i_fpu_res      = fpu_res_val;
   assign i_fpu_overflow = fpu_ovf_val;
   assign i_fpu_res_vld  = fpu_vld_d | late_vld | (fpu_en && fpu_lat == 0 && o_fpu_vld);

   // Latency-L FPU: result valid L cycles after the issue cycle
   initial begin
      fpu_vld_d = 1'b0;
      pend      = 0;
      forever begin
         @(posedge clk);
         #1;
         fpu_vld_d = 1'b0;
         if (rst) begin
            pend = 0;
         end else begin
            if (pend > 0) begin
               pend--;
               if (pend == 0) fpu_vld_d = 1'b1;
            end
            if (o_fpu_vld && fpu_en && fpu_lat > 0) pend = fpu_lat;
         end
      end
   end

   // Writeback monitor
   initial begin
      wb_exp_t e;
      forever begin
         @(negedge clk);
         if (o_wb_vld && i_wb_rdy) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("[TB] FAIL wb_unexpected: got rd=%0d data=%h, required no writeback", o_wb_rd, o_wb_data);
            end else begin
               e = exp_q.pop_front();
               if (o_wb_rd !== e.rd || o_wb_data !== e.data) begin
                  errors++;
                  $display("[TB] FAIL wb_data: got rd=%0d data=%h, required rd=%0d data=%h",
                           o_wb_rd, o_wb_data, e.rd, e.data);
               end
            end
         end
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // Present one instruction and return #1 after the edge that accepts it
   task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                input logic [2:0] rd, input bit exp_wb, input logic [15:0] exp_data);
      int n = 0;
      wb_exp_t e;
      i_req_vld  = 1'b1;
      i_opcode   = op;
      i_rs1_data = a;
      i_rs2_data = b;
      i_rd       = rd;
      while (!o_req_rdy && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) begin
         checkOutput("req_rdy_wait", 64'(o_req_rdy), 64'd1);
      end
      if (exp_wb) begin
         e.rd   = rd;
         e.data = exp_data;
         exp_q.push_back(e);
      end
      tick();
      i_req_vld = 1'b0;
   endtask

   initial begin
      int n;
      int vld_cnt;
      bit busy_ok;

      rst = 1'b1; i_req_vld = 1'b0; i_opcode = '0; i_rs1_data = '0; i_rs2_data = '0;
      i_rd = '0; i_wb_rdy = 1'b1; i_ovf_clr = 1'b0;
      fpu_en = 1'b1; fpu_lat = 0; fpu_res_val = '0; fpu_ovf_val = 1'b0; late_vld = 1'b0;
      tick(); tick();
      rst = 1'b0;
      #1;
      checkOutput("reset_state",
                  {o_req_rdy, o_fpu_vld, o_fpu_a, o_fpu_b, o_fpu_opcode, o_wb_vld, o_wb_rd, o_wb_data,
                   o_busy, o_illegal, o_timeout, o_ovf_sticky},
                  {1'b1, 1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0});

      $display("[TB] add, zero-latency FPU");
      fpu_res_val = 16'h4200;
      applyStimulus(4'b1110, 16'h3C00, 16'h4000, 3'd2, 1'b1, 16'h4200);
      checkOutput("add_issue", {o_fpu_vld, o_fpu_a, o_fpu_b, o_fpu_opcode, o_wb_vld, o_req_rdy},
                  {1'b1, 16'h3C00, 16'h4000, 4'b1110, 1'b0, 1'b0});
      tick();
      checkOutput("add_wb", {o_fpu_vld, o_wb_vld, o_wb_rd, o_wb_data, o_req_rdy},
                  {1'b0, 1'b1, 3'd2, 16'h4200, 1'b0});
      tick();
      checkOutput("add_rdy_again", {o_req_rdy, o_wb_vld, o_busy}, {1'b1, 1'b0, 1'b0});

      $display("[TB] mul, 4-cycle FPU");
      fpu_lat = 4; fpu_res_val = 16'h4600;
      applyStimulus(4'b1111, 16'h4000, 16'h4200, 3'd1, 1'b1, 16'h4600);
      checkOutput("mul_issue", 64'(o_fpu_vld), 64'd1);
      vld_cnt = 1; busy_ok = 1'b1; n = 0;
      while (!o_wb_vld && n < 20) begin
         tick();
         n++;
         if (o_fpu_vld) vld_cnt++;
         if (!o_busy) busy_ok = 1'b0;
      end
      checkOutput("mul_wb_cycle", 64'(n), 64'd5);
      checkOutput("mul_single_issue", 64'(vld_cnt), 64'd1);
      checkOutput("mul_busy", 64'(busy_ok), 64'd1);
      tick();

      $display("[TB] overflow and sticky");
      fpu_lat = 0; fpu_res_val = 16'h7C00; fpu_ovf_val = 1'b1;
      applyStimulus(4'b1111, 16'h7BFF, 16'h4000, 3'd3, 1'b1, 16'h7C00);
      tick();
      checkOutput("ovf_set", {o_ovf_sticky, o_wb_vld, o_wb_data}, {1'b1, 1'b1, 16'h7C00});
      tick();
      applyStimulus(4'b1111, 16'h7BFF, 16'h4000, 3'd4, 1'b1, 16'h7C00);
      i_ovf_clr = 1'b1;
      tick();
      i_ovf_clr = 1'b0;
      checkOutput("ovf_set_beats_clr", 64'(o_ovf_sticky), 64'd1);
      tick();
      fpu_ovf_val = 1'b0;
      i_ovf_clr = 1'b1;
      tick();
      i_ovf_clr = 1'b0;
      checkOutput("ovf_clr", 64'(o_ovf_sticky), 64'd0);

      $display("[TB] writeback backpressure");
      fpu_res_val = 16'h5555;
      i_wb_rdy = 1'b0;
      applyStimulus(4'b1110, 16'h1111, 16'h2222, 3'd5, 1'b1, 16'h5555);
      tick();
      for (int i = 0; i < 5; i++) begin
         checkOutput("bp_hold", {o_wb_vld, o_wb_rd, o_wb_data, o_req_rdy}, {1'b1, 3'd5, 16'h5555, 1'b0});
         tick();
      end
      i_wb_rdy = 1'b1;
      tick();
      checkOutput("bp_release", {o_wb_vld, o_req_rdy}, {1'b0, 1'b1});
      tick(); tick();
      checkOutput("bp_single_transfer", 64'(exp_q.size()), 64'd0);

      $display("[TB] timeout");
      fpu_en = 1'b0;
      applyStimulus(4'b1110, 16'h3C00, 16'h3C00, 3'd1, 1'b0, 16'h0);
      checkOutput("to_issue", 64'(o_fpu_vld), 64'd1);
      n = 0;
      tick();
      while (!o_timeout && n < 40) begin
         n++;
         tick();
      end
      checkOutput("to_wait_cycles", 64'(n), 64'd15);
      checkOutput("to_idle", {o_busy, o_req_rdy, o_wb_vld}, {1'b0, 1'b1, 1'b0});
      tick();
      checkOutput("to_pulse_len", 64'(o_timeout), 64'd0);

      $display("[TB] illegal opcode");
      applyStimulus(4'b0101, 16'hAAAA, 16'hBBBB, 3'd6, 1'b0, 16'h0);
      checkOutput("ill_pulse", {o_illegal, o_fpu_vld, o_busy}, {1'b1, 1'b0, 1'b0});
      tick();
      checkOutput("ill_end", {o_illegal, o_fpu_vld}, {1'b0, 1'b0});

      $display("[TB] reset during WAIT");
      fpu_en = 1'b1; fpu_lat = 0; fpu_res_val = 16'h7C00; fpu_ovf_val = 1'b1;
      applyStimulus(4'b1110, 16'h3C00, 16'h3C00, 3'd6, 1'b1, 16'h7C00);
      tick(); tick();
      checkOutput("rst_pre_sticky", 64'(o_ovf_sticky), 64'd1);
      fpu_en = 1'b0; fpu_res_val = 16'h1234; fpu_ovf_val = 1'b1;
      applyStimulus(4'b1111, 16'h4000, 16'h4000, 3'd7, 1'b0, 16'h0);
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      late_vld = 1'b1;
      tick();
      late_vld = 1'b0;
      checkOutput("rst_mid_wait",
                  {o_req_rdy, o_fpu_vld, o_fpu_a, o_fpu_b, o_fpu_opcode, o_wb_vld, o_wb_rd, o_wb_data,
                   o_busy, o_illegal, o_timeout, o_ovf_sticky},
                  {1'b1, 1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0});
      tick(); tick();
      checkOutput("rst_no_wb", 64'(o_wb_vld), 64'd0);

      checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fpu_dispatch.md
Name: fpu_dispatch

Overview:
- Issue-side controller that feeds the half-precision FPU (add, opcode 4'b1110; mul, opcode 4'b1111) from the pipeline execute stage.
- Accepts one FP instruction at a time, registers the operands and drives a single-cycle valid to the FPU.
- Waits for the FPU result valid, or for a timeout, then presents the result on a ready/valid writeback port toward the register file.
- Keeps a sticky overflow status bit, and stalls the pipeline while busy.

Parameters:
- DATA_W, 16, operand/result width (IEEE fp16)
- RD_W, 3, destination register index width
- TIMEOUT, 15, maximum cycles in WAIT before abort; legal range 1..255
- CNT_W, 8, timeout counter width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i_req_vld  in  1  pipeline presents an FP instruction
- o_req_rdy  out  1  dispatcher can accept; high only in IDLE
- i_opcode  in  4  instruction opcode
- i_rs1_data  in  DATA_W  operand A
- i_rs2_data  in  DATA_W  operand B
- i_rd  in  RD_W  destination register
- o_fpu_vld  out  1  one-cycle issue strobe to the FPU
- o_fpu_a  out  DATA_W  registered operand A
- o_fpu_b  out  DATA_W  registered operand B
- o_fpu_opcode  out  4  registered opcode
- i_fpu_res  in  DATA_W  FPU result
- i_fpu_res_vld  in  1  FPU result valid
- i_fpu_overflow  in  1  FPU overflow, qualified by i_fpu_res_vld
- o_wb_vld  out  1  writeback valid
- o_wb_rd  out  RD_W  writeback destination
- o_wb_data  out  DATA_W  writeback data
- i_wb_rdy  in  1  register file accepts writeback
- o_busy  out  1  high in any state other than IDLE; drives pipeline stall
- o_illegal  out  1  one-cycle pulse when a non-FP opcode is accepted
- o_timeout  out  1  one-cycle pulse when WAIT aborts
- o_ovf_sticky  out  1  set by any captured overflow
- i_ovf_clr  in  1  clears o_ovf_sticky

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; all outputs 0 except o_req_rdy=1.
  - Operand, rd and result registers are cleared to 0; counter=0.
  - Reset mid-operation discards the in-flight op. No writeback, no pulses. A late i_fpu_res_vld arriving in IDLE is ignored.
- FSM states: IDLE, ISSUE, WAIT, WB.
- IDLE:
  - Accept when i_req_vld & o_req_rdy. Latch a/b/opcode/rd.
  - Opcode 1110 or 1111 -> ISSUE.
  - Any other opcode -> o_illegal=1 for the next cycle; stay IDLE; no FPU issue.
- ISSUE:
  - o_fpu_vld=1 for exactly this cycle; o_fpu_a/b/opcode stable from here until return to IDLE.
  - If i_fpu_res_vld=1 in this same cycle (combinational FPU), capture result and overflow -> WB.
  - Otherwise -> WAIT with counter=1.
- WAIT:
  - On i_fpu_res_vld, capture i_fpu_res into o_wb_data and the overflow bit -> WB.
  - Otherwise counter++. When counter==TIMEOUT with no result -> o_timeout=1 next cycle; -> IDLE; no writeback.
  - Result valid and timeout in the same cycle: the result wins.
- WB:
  - o_wb_vld=1, with o_wb_rd/o_wb_data held stable until i_wb_rdy=1. Transfer completes on o_wb_vld & i_wb_rdy -> IDLE.
  - No back-to-back accept in the transfer cycle: o_req_rdy rises the cycle after.
- Latency: accept at edge N; o_fpu_vld during cycle N+1; with a zero-latency FPU and i_wb_rdy=1, o_wb_vld during cycle N+2; o_req_rdy again in N+3. Throughput is 1 op per 3 cycles minimum.
- Sticky overflow:
  - Set on capture with i_fpu_overflow=1.
  - i_ovf_clr clears it; simultaneous set and clear -> set wins.
  - Overflowed results are still written back.
- o_busy = (state != IDLE). o_req_rdy = (state == IDLE) & ~rst.

Decomposition:
- Shared package fpu_pkg:
  - Opcode constants OP_FADD=4'b1110, OP_FMUL=4'b1111.
  - State encoding for IDLE/ISSUE/WAIT/WB.
  - DATA_W default.
- One natural sub-module, fpu_wb_slot: a single-entry ready/valid holding register for rd/data, reusable for other writeback sources.

Test Plan:
- Add with zero-latency FPU model: a=0x3C00, b=0x4000, op=1110, rd=2, i_wb_rdy=1 -> o_fpu_vld one cycle at N+1; o_wb_vld at N+2 with rd=2, data=0x4200; o_req_rdy high at N+3.
- Mul with 4-cycle FPU model: a=0x4000, b=0x4200, op=1111 -> o_busy high throughout; o_wb_data=0x4600; o_fpu_vld exactly one cycle.
- Overflow: 0x7BFF * 0x4000, FPU returns 0x7C00 with overflow=1 -> writeback 0x7C00, o_ovf_sticky=1; assert i_ovf_clr on a cycle with a new overflow capture -> sticky stays 1; clear alone -> 0.
- Backpressure: i_wb_rdy low for 5 cycles -> o_wb_vld, rd and data stable, o_req_rdy=0; release -> one transfer only.
- Timeout and illegal:
  - TIMEOUT=15, FPU never responds -> o_timeout pulse 15 cycles after ISSUE, no o_wb_vld, back to IDLE.
  - op=0101 -> o_illegal pulse, no o_fpu_vld.
- Reset mid-WAIT: assert rst during WAIT, then drive i_fpu_res_vld after reset -> no writeback; all outputs at reset values; o_ovf_sticky=0.
